// File: rtl/basic_block.sv
// ============================================================================
// Module      : basic_block
// Description : Regex-engine thread step. Accepts one thread PC, fetches its
//               instruction word, decodes it against the current character
//               and emits zero, one or two spawned-thread PCs.
// Options     : BASIC_BLOCK_EXTENDED_OPS_EN enables MATCH_ANY and NOT_MATCH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module basic_block #(
  parameter int PC_WIDTH          = 8,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHARACTER_WIDTH-1:0]   current_character,
  input  logic                         input_pc_valid,
  input  logic [PC_WIDTH-1:0]          input_pc,
  output logic                         input_pc_ready,
  output logic                         memory_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0] memory_addr,
  input  logic                         memory_ready,
  input  logic [MEMORY_WIDTH-1:0]      memory_data,
  output logic                         output_pc_valid,
  output logic [PC_WIDTH-1:0]          output_pc,
  input  logic                         output_pc_ready,
  output logic                         output_pc_is_directed_to_current,
  output logic                         accepts
);

  // Instruction set shared with the program compiler.
  localparam logic [7:0] OP_ACCEPT    = 8'h00;
  localparam logic [7:0] OP_SPLIT     = 8'h01;
  localparam logic [7:0] OP_MATCH     = 8'h02;
  localparam logic [7:0] OP_JMP       = 8'h03;
  localparam logic [7:0] OP_MATCH_ANY = 8'h04;
  localparam logic [7:0] OP_NOT_MATCH = 8'h05;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_DATA = 3'd2,
    OUT1      = 3'd3,
    OUT2      = 3'd4
  } state_t;

  state_t state, state_next;

  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] second_pc;
  logic                has_second;

  logic [7:0]          opcode;
  logic [7:0]          operand;
  logic [PC_WIDTH-1:0] pc_plus_one;
  logic [PC_WIDTH-1:0] pc_plus_operand;
  logic                char_is_zero;
  logic                char_eq_operand;
  logic                dec_emit;
  logic                dec_second;
  logic                dec_dir;
  logic                dec_accept;
  logic [PC_WIDTH-1:0] dec_pc1;

  // Instruction decode; only meaningful in WAIT_DATA when memory_data is valid.
  always_comb begin
    opcode          = memory_data[15:8];
    operand         = memory_data[7:0];
    pc_plus_one     = pc_reg + PC_WIDTH'(1);
    pc_plus_operand = pc_reg + PC_WIDTH'(operand);
    char_is_zero    = (current_character == '0);
    char_eq_operand = (current_character == CHARACTER_WIDTH'(operand));
    dec_emit        = 1'b0;
    dec_second      = 1'b0;
    dec_dir         = 1'b0;
    dec_accept      = 1'b0;
    dec_pc1         = pc_plus_one;
    case (opcode)
      OP_ACCEPT: dec_accept = char_is_zero;
      OP_SPLIT: begin
        dec_emit   = 1'b1;
        dec_second = 1'b1;
        dec_dir    = 1'b1;
      end
      OP_MATCH:  dec_emit = char_eq_operand;
      OP_JMP: begin
        dec_emit = 1'b1;
        dec_dir  = 1'b1;
        dec_pc1  = pc_plus_operand;
      end
`ifdef BASIC_BLOCK_EXTENDED_OPS_EN
      OP_MATCH_ANY: dec_emit = !char_is_zero;
      OP_NOT_MATCH: dec_emit = !char_eq_operand && !char_is_zero;
`else
      OP_MATCH_ANY: dec_emit = 1'b0;
      OP_NOT_MATCH: dec_emit = 1'b0;
`endif
      default:   dec_emit = 1'b0;
    endcase
  end

  // State register; reset abandons any thread in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_next      = state;
    input_pc_ready  = 1'b0;
    memory_valid    = 1'b0;
    output_pc_valid = 1'b0;
    case (state)
      IDLE: begin
        input_pc_ready = 1'b1;
        if (input_pc_valid) state_next = FETCH;
      end
      FETCH: begin
        memory_valid = 1'b1;
        if (memory_ready) state_next = WAIT_DATA;
      end
      WAIT_DATA: begin
        state_next = dec_emit ? OUT1 : IDLE;
      end
      OUT1: begin
        output_pc_valid = 1'b1;
        if (output_pc_ready) state_next = has_second ? OUT2 : IDLE;
      end
      OUT2: begin
        output_pc_valid = 1'b1;
        if (output_pc_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: PC latch, fetch address, decoded output PCs and accept pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg                           <= '0;
      memory_addr                      <= '0;
      output_pc                        <= '0;
      second_pc                        <= '0;
      has_second                       <= 1'b0;
      output_pc_is_directed_to_current <= 1'b0;
      accepts                          <= 1'b0;
    end else begin
      accepts <= (state == WAIT_DATA) && dec_accept;
      if (state == IDLE && input_pc_valid) begin
        pc_reg      <= input_pc;
        memory_addr <= MEMORY_ADDR_WIDTH'(input_pc);
      end
      if (state == WAIT_DATA) begin
        output_pc                        <= dec_pc1;
        second_pc                        <= pc_plus_operand;
        has_second                       <= dec_second;
        output_pc_is_directed_to_current <= dec_dir;
      end
      if (state == OUT1 && output_pc_ready && has_second) begin
        output_pc <= second_pc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_basic_block.sv
// ============================================================================
// Module      : tb_basic_block
// Description : Directed self-checking bench for basic_block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_basic_block;

  logic        clk;
  logic        reset;
  logic [7:0]  current_character;
  logic        input_pc_valid;
  logic [7:0]  input_pc;
  logic        input_pc_ready;
  logic        memory_valid;
  logic [10:0] memory_addr;
  logic        memory_ready;
  logic [15:0] memory_data;
  logic        output_pc_valid;
  logic [7:0]  output_pc;
  logic        output_pc_ready;
  logic        output_pc_is_directed_to_current;
  logic        accepts;

  int vectors    = 0;
  int miscompares = 0;

  basic_block dut (
    .clk                              (clk),
    .reset                            (reset),
    .current_character                (current_character),
    .input_pc_valid                   (input_pc_valid),
    .input_pc                         (input_pc),
    .input_pc_ready                   (input_pc_ready),
    .memory_valid                     (memory_valid),
    .memory_addr                      (memory_addr),
    .memory_ready                     (memory_ready),
    .memory_data                      (memory_data),
    .output_pc_valid                  (output_pc_valid),
    .output_pc                        (output_pc),
    .output_pc_ready                  (output_pc_ready),
    .output_pc_is_directed_to_current (output_pc_is_directed_to_current),
    .accepts                          (accepts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Push one PC through fetch and decode; returns at the negedge after decode.
  task automatic run_fetch(input logic [7:0] pc, input logic [15:0] word,
                           input logic [7:0] ch, input int gnt_delay);
    input_pc       = pc;
    input_pc_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    input_pc_valid = 1'b0;
    vectors++;
    if (memory_valid !== 1'b1 || memory_addr !== {3'b000, pc}) begin
      $display("FAIL fetch_req: valid=%b addr=%h, want 1/%h", memory_valid, memory_addr, {3'b000, pc});
      miscompares++;
    end
    for (int i = 0; i < gnt_delay; i++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if (memory_valid !== 1'b1 || input_pc_ready !== 1'b0) begin
        $display("FAIL fetch_hold: valid=%b ready=%b, want 1/0", memory_valid, input_pc_ready);
        miscompares++;
      end
    end
    memory_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    memory_ready      = 1'b0;
    memory_data       = word;
    current_character = ch;
    vectors++;
    if (memory_valid !== 1'b0) begin
      $display("FAIL wait_data_memvalid: got %b, want 0", memory_valid);
      miscompares++;
    end
    @(posedge clk); @(negedge clk);
    memory_data       = 16'hDEAD;
    current_character = 8'hEE;
  endtask

  // Complete an output handshake on the current negedge.
  task automatic handshake;
    output_pc_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    output_pc_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (input_pc_ready !== 1'b1 || memory_valid !== 1'b0 || output_pc_valid !== 1'b0 ||
        accepts !== 1'b0 || output_pc !== 8'h00 || output_pc_is_directed_to_current !== 1'b0 ||
        memory_addr !== 11'h000) begin
      $display("FAIL reset_state: rdy=%b mv=%b ov=%b acc=%b opc=%h dir=%b addr=%h, want 1/0/0/0/00/0/000",
               input_pc_ready, memory_valid, output_pc_valid, accepts, output_pc,
               output_pc_is_directed_to_current, memory_addr);
      miscompares++;
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_split;
    run_fetch(8'hAB, 16'h0111, 8'h00, 2);
    vectors++;
    if (output_pc_valid !== 1'b1 || output_pc !== 8'hAC || output_pc_is_directed_to_current !== 1'b1) begin
      $display("FAIL split_out1: v=%b pc=%h dir=%b, want 1/ac/1", output_pc_valid, output_pc,
               output_pc_is_directed_to_current);
      miscompares++;
    end
    vectors++;
    if (input_pc_ready !== 1'b0) begin
      $display("FAIL split_busy_ready: got %b, want 0", input_pc_ready);
      miscompares++;
    end
    handshake();
    vectors++;
    if (output_pc_valid !== 1'b1 || output_pc !== 8'hBC || output_pc_is_directed_to_current !== 1'b1) begin
      $display("FAIL split_out2: v=%b pc=%h dir=%b, want 1/bc/1", output_pc_valid, output_pc,
               output_pc_is_directed_to_current);
      miscompares++;
    end
    handshake();
    vectors++;
    if (output_pc_valid !== 1'b0 || input_pc_ready !== 1'b1) begin
      $display("FAIL split_idle: v=%b rdy=%b, want 0/1", output_pc_valid, input_pc_ready);
      miscompares++;
    end
  endtask

  task automatic test_match;
    run_fetch(8'h10, 16'h0261, 8'h61, 0);
    vectors++;
    if (output_pc_valid !== 1'b1 || output_pc !== 8'h11 || output_pc_is_directed_to_current !== 1'b0) begin
      $display("FAIL match_hit: v=%b pc=%h dir=%b, want 1/11/0", output_pc_valid, output_pc,
               output_pc_is_directed_to_current);
      miscompares++;
    end
    handshake();
    vectors++;
    if (output_pc_valid !== 1'b0 || input_pc_ready !== 1'b1) begin
      $display("FAIL match_hit_idle: v=%b rdy=%b, want 0/1", output_pc_valid, input_pc_ready);
      miscompares++;
    end
    run_fetch(8'h10, 16'h0261, 8'h62, 0);
    vectors++;
    if (output_pc_valid !== 1'b0 || input_pc_ready !== 1'b1) begin
      $display("FAIL match_miss: v=%b rdy=%b, want 0/1", output_pc_valid, input_pc_ready);
      miscompares++;
    end
  endtask

  task automatic test_accept;
    run_fetch(8'h20, 16'h0000, 8'h00, 0);
    vectors++;
    if (accepts !== 1'b1 || output_pc_valid !== 1'b0) begin
      $display("FAIL accept_pulse: acc=%b v=%b, want 1/0", accepts, output_pc_valid);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (accepts !== 1'b0 || output_pc_valid !== 1'b0 || input_pc_ready !== 1'b1) begin
      $display("FAIL accept_one_cycle: acc=%b v=%b rdy=%b, want 0/0/1", accepts, output_pc_valid, input_pc_ready);
      miscompares++;
    end
    run_fetch(8'h20, 16'h0000, 8'h41, 0);
    vectors++;
    if (accepts !== 1'b0 || output_pc_valid !== 1'b0) begin
      $display("FAIL accept_nonzero_char: acc=%b v=%b, want 0/0", accepts, output_pc_valid);
      miscompares++;
    end
  endtask

  task automatic test_jmp_wrap;
    run_fetch(8'hFF, 16'h0302, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (output_pc_valid !== 1'b1 || output_pc !== 8'h01 || output_pc_is_directed_to_current !== 1'b1) begin
        $display("FAIL jmp_hold[%0d]: v=%b pc=%h dir=%b, want 1/01/1", i, output_pc_valid, output_pc,
                 output_pc_is_directed_to_current);
        miscompares++;
      end
      @(negedge clk);
    end
    handshake();
    vectors++;
    if (output_pc_valid !== 1'b0 || input_pc_ready !== 1'b1) begin
      $display("FAIL jmp_idle: v=%b rdy=%b, want 0/1", output_pc_valid, input_pc_ready);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid;
    input_pc       = 8'h55;
    input_pc_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    input_pc_valid = 1'b0;
    reset = 1'b1;
    #1;
    vectors++;
    if (memory_valid !== 1'b0 || input_pc_ready !== 1'b1) begin
      $display("FAIL reset_in_fetch: mv=%b rdy=%b, want 0/1", memory_valid, input_pc_ready);
      miscompares++;
    end
    @(negedge clk);
    reset        = 1'b0;
    memory_ready = 1'b1;
    memory_data  = 16'h0301;
    repeat (3) @(negedge clk);
    memory_ready = 1'b0;
    vectors++;
    if (output_pc_valid !== 1'b0 || memory_valid !== 1'b0 || input_pc_ready !== 1'b1) begin
      $display("FAIL reset_abandon: ov=%b mv=%b rdy=%b, want 0/0/1", output_pc_valid, memory_valid, input_pc_ready);
      miscompares++;
    end
  endtask

  task automatic test_ext_ops;
    logic exp_v;
`ifdef BASIC_BLOCK_EXTENDED_OPS_EN
    exp_v = 1'b1;
`else
    exp_v = 1'b0;
`endif
    run_fetch(8'h30, 16'h0400, 8'h41, 0);
    vectors++;
    if (output_pc_valid !== exp_v || (exp_v && (output_pc !== 8'h31 || output_pc_is_directed_to_current !== 1'b0))) begin
      $display("FAIL match_any: v=%b pc=%h dir=%b, want v=%b pc=31 dir=0", output_pc_valid, output_pc,
               output_pc_is_directed_to_current, exp_v);
      miscompares++;
    end
    if (output_pc_valid) handshake();
    run_fetch(8'h40, 16'h0541, 8'h42, 0);
    vectors++;
    if (output_pc_valid !== exp_v || (exp_v && (output_pc !== 8'h41 || output_pc_is_directed_to_current !== 1'b0))) begin
      $display("FAIL not_match_diff: v=%b pc=%h dir=%b, want v=%b pc=41 dir=0", output_pc_valid, output_pc,
               output_pc_is_directed_to_current, exp_v);
      miscompares++;
    end
    if (output_pc_valid) handshake();
    run_fetch(8'h40, 16'h0541, 8'h41, 0);
    vectors++;
    if (output_pc_valid !== 1'b0) begin
      $display("FAIL not_match_equal: v=%b, want 0", output_pc_valid);
      miscompares++;
    end
    run_fetch(8'h40, 16'h0400, 8'h00, 0);
    vectors++;
    if (output_pc_valid !== 1'b0) begin
      $display("FAIL match_any_zero: v=%b, want 0", output_pc_valid);
      miscompares++;
    end
    run_fetch(8'h50, 16'h0761, 8'h61, 0);
    vectors++;
    if (output_pc_valid !== 1'b0 || accepts !== 1'b0 || input_pc_ready !== 1'b1) begin
      $display("FAIL undefined_op: v=%b acc=%b rdy=%b, want 0/0/1", output_pc_valid, accepts, input_pc_ready);
      miscompares++;
    end
  endtask

  initial begin
    reset             = 1'b1;
    current_character = 8'h00;
    input_pc_valid    = 1'b0;
    input_pc          = 8'h00;
    memory_ready      = 1'b0;
    memory_data       = 16'hDEAD;
    output_pc_ready   = 1'b0;
    test_reset();
    test_split();
    test_match();
    test_accept();
    test_jmp_wrap();
    test_reset_mid();
    test_ext_ops();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
